// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART rate table, divisor/threshold helpers and select codes
package uart_pkg;

  localparam int unsigned NUM_RATES = 10;

  localparam logic [3:0] BAUD_9600    = 4'd0;
  localparam logic [3:0] BAUD_19200   = 4'd1;
  localparam logic [3:0] BAUD_38400   = 4'd2;
  localparam logic [3:0] BAUD_57600   = 4'd3;
  localparam logic [3:0] BAUD_115200  = 4'd4;
  localparam logic [3:0] BAUD_230400  = 4'd5;
  localparam logic [3:0] BAUD_460800  = 4'd6;
  localparam logic [3:0] BAUD_921600  = 4'd7;
  localparam logic [3:0] BAUD_1000000 = 4'd8;
  localparam logic [3:0] BAUD_1500000 = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT_FALL,
    ST_MEASURE,
    ST_CLASSIFY
  } autobaud_state_e;

  function automatic int unsigned baud_rate(input int unsigned code);
    case (code)
      0:       return 9600;
      1:       return 19200;
      2:       return 38400;
      3:       return 57600;
      4:       return 115200;
      5:       return 230400;
      6:       return 460800;
      7:       return 921600;
      8:       return 1000000;
      default: return 1500000;
    endcase
  endfunction

  // Elaboration-time only: callers pass a parameter, so no divider is built.
  function automatic logic [31:0] baud_divisor(input int unsigned clk_hz, input int unsigned code);
    return 32'(clk_hz / baud_rate(code));
  endfunction

  // Midpoint between adjacent divisors; a count at or above it belongs to the slower rate.
  function automatic logic [31:0] baud_threshold(input int unsigned clk_hz, input int unsigned code);
    return (baud_divisor(clk_hz, code) + baud_divisor(clk_hz, code + 1)) / 32'd2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous bit
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - measures one start-bit low time and maps it to a baud select code
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int unsigned FPGA_CLK = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_start,
  output logic [3:0] o_baud_select,
  output logic       o_update_baud,
  output logic       o_busy,
  output logic       o_error
);

  localparam logic [31:0] TIMEOUT_COUNT = 32'd2 * baud_divisor(FPGA_CLK, 0);
  localparam logic [31:0] GLITCH_COUNT  = baud_divisor(FPGA_CLK, 9) / 32'd2;

  localparam logic [31:0] THRESH [9] = '{
    baud_threshold(FPGA_CLK, 0), baud_threshold(FPGA_CLK, 1), baud_threshold(FPGA_CLK, 2),
    baud_threshold(FPGA_CLK, 3), baud_threshold(FPGA_CLK, 4), baud_threshold(FPGA_CLK, 5),
    baud_threshold(FPGA_CLK, 6), baud_threshold(FPGA_CLK, 7), baud_threshold(FPGA_CLK, 8)
  };

  logic            rx_s;
  autobaud_state_e state_q, state_d;
  logic [31:0]     count_q, count_d;
  logic [3:0]      baud_q, baud_d;
  logic            update_q, update_d;
  logic            error_q, error_d;
  logic [3:0]      class_sel;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // Walk from the fastest threshold down so the slowest matching rate wins.
  always_comb begin
    class_sel = BAUD_1500000;
    for (int k = 8; k >= 0; k--) begin
      if (count_q >= THRESH[k]) class_sel = 4'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    baud_d   = baud_q;
    update_d = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (rx_s) state_d = ST_WAIT_FALL;
      end
      ST_WAIT_FALL: begin
        if (!rx_s) begin
          state_d = ST_MEASURE;
          count_d = 32'd1;
        end
      end
      ST_MEASURE: begin
        if (rx_s) begin
          state_d = ST_CLASSIFY;
        end else begin
          count_d = count_q + 32'd1;
          if (count_q >= TIMEOUT_COUNT) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_CLASSIFY: begin
        if (count_q < GLITCH_COUNT) begin
          error_d = 1'b1;
          state_d = ST_WAIT_FALL;
        end else begin
          baud_d   = class_sel;
          update_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 32'd0;
      baud_q   <= BAUD_9600;
      update_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      update_q <= update_d;
      error_q  <= error_d;
    end
  end

  assign o_baud_select = baud_q;
  assign o_update_baud = update_q;
  assign o_error       = error_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_autobaud.sv
// tb/tb_uart_autobaud.sv - directed bench with a behavioural line-timing model of uart_autobaud
module tb_uart_autobaud;

  localparam int unsigned CLK_HZ = 100_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       start = 1'b0;
  logic [3:0] sel;
  logic       upd;
  logic       busy;
  logic       err;

  uart_autobaud #(.FPGA_CLK(CLK_HZ)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx          (rx),
    .i_start       (start),
    .o_baud_select (sel),
    .o_update_baud (upd),
    .o_busy        (busy),
    .o_error       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen = 0;
  int err_seen = 0;

  int rates [10] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600, 1000000, 1500000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int divisor(input int k);
    return CLK_HZ / rates[k];
  endfunction

  function automatic int rate_code(input int low_cycles);
    for (int k = 0; k < 9; k++) begin
      if (low_cycles >= (divisor(k) + divisor(k + 1)) / 2) return k;
    end
    return 9;
  endfunction

  // Model: what the line has done since arming, seen through two cycles of synchronizer delay.
  localparam int P_OFF = 0, P_NEED_HIGH = 1, P_NEED_FALL = 2, P_LOW_RUN = 3, P_DECIDE = 4;
  int         m_phase;
  int         m_run;
  logic [3:0] m_sel;
  logic       m_upd, m_err;
  logic       m_s1, m_s2, m_rs;
  bit         m_valid = 0;

  always @(posedge clk) begin
    m_upd = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      m_phase = P_OFF;
      m_run   = 0;
      m_sel   = 4'd0;
      m_s1    = 1'b1;
      m_s2    = 1'b1;
    end else begin
      m_rs = m_s2;
      m_s2 = m_s1;
      m_s1 = rx;
      if (m_phase == P_OFF) begin
        if (start) m_phase = P_NEED_HIGH;
      end else if (m_phase == P_NEED_HIGH) begin
        if (m_rs) m_phase = P_NEED_FALL;
      end else if (m_phase == P_NEED_FALL) begin
        if (!m_rs) begin m_phase = P_LOW_RUN; m_run = 1; end
      end else if (m_phase == P_LOW_RUN) begin
        if (m_rs) m_phase = P_DECIDE;
        else begin
          m_run++;
          if (m_run > 2 * divisor(0)) begin m_err = 1'b1; m_phase = P_OFF; end
        end
      end else begin
        if (m_run < divisor(9) / 2) begin m_err = 1'b1; m_phase = P_NEED_FALL; end
        else begin m_sel = 4'(rate_code(m_run)); m_upd = 1'b1; m_phase = P_OFF; end
      end
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("sel", sel, m_sel);
      check("update", upd, m_upd);
      check("error", err, m_err);
      check("busy", busy, m_phase != P_OFF);
      if (upd) upd_seen++;
      if (err) err_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(5);
  endtask

  task automatic low_pulse(input int n);
    rx = 1'b0;
    idle(n);
    rx = 1'b1;
    idle(10);
  endtask

  task automatic send_byte(input logic [7:0] data, input int bit_cycles);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      idle(bit_cycles);
    end
    rx = 1'b1;
  endtask

  int u0, e0;

  initial begin
    idle(4);
    check("reset_sel", sel, 0);
    check("reset_busy", busy, 0);
    check("reset_update", upd, 0);
    check("reset_error", err, 0);
    rst_n = 1'b1;
    idle(5);

    check("D0", divisor(0), 10416);
    check("D4", divisor(4), 868);
    check("D9", divisor(9), 66);
    check("T0", (divisor(0) + divisor(1)) / 2, 7812);
    check("T3", (divisor(3) + divisor(4)) / 2, 1302);
    check("T4", (divisor(4) + divisor(5)) / 2, 651);
    check("T8", (divisor(8) + divisor(9)) / 2, 83);
    check("model_7812", rate_code(7812), 0);
    check("model_7811", rate_code(7811), 1);
    check("model_82", rate_code(82), 9);

    u0 = upd_seen;
    arm();
    send_byte(8'h55, 868);
    idle(20);
    check("byte55_sel", sel, 4);
    check("byte55_updates", upd_seen - u0, 1);
    check("byte55_busy", busy, 0);

    arm();
    low_pulse(7812);
    check("t0_edge_sel", sel, 0);
    arm();
    low_pulse(7811);
    check("t0_below_sel", sel, 1);

    e0 = err_seen;
    arm();
    low_pulse(20);
    check("glitch_errors", err_seen - e0, 1);
    check("glitch_still_busy", busy, 1);
    check("glitch_sel_kept", sel, 1);
    low_pulse(66);
    check("d9_sel", sel, 9);

    e0 = err_seen;
    u0 = upd_seen;
    arm();
    rx = 1'b0;
    idle(30000);
    rx = 1'b1;
    idle(10);
    check("timeout_errors", err_seen - e0, 1);
    check("timeout_updates", upd_seen - u0, 0);
    check("timeout_busy", busy, 0);
    check("timeout_sel", sel, 9);

    rx = 1'b0;
    idle(50);
    arm();
    idle(100);
    check("low_armed_busy", busy, 1);
    check("low_armed_sel", sel, 9);
    rx = 1'b1;
    idle(20);
    rx = 1'b0;
    idle(400);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(467);
    rx = 1'b1;
    idle(10);
    check("rearm_sel", sel, 4);
    check("rearm_busy", busy, 0);

    u0 = upd_seen;
    arm();
    rx = 1'b0;
    idle(500);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_sel", sel, 0);
    check("midreset_busy", busy, 0);
    check("midreset_update", upd, 0);
    check("midreset_error", err, 0);
    rst_n = 1'b1;
    idle(300);
    rx = 1'b1;
    idle(20);
    check("midreset_no_update", upd_seen - u0, 0);
    check("midreset_sel_after", sel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
